// File: rtl/propagation_time_counter_pkg.sv
// Shared constants and FSM encoding for the propagation time counter and its readout stage.
package propagation_time_counter_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 50000;

  // Number of COUNT cycles during which the echo pipeline still carries pre-start history
  localparam logic [1:0] BLANK_CYCLES = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/propagation_time_counter_if.sv
// Start/echo inputs and result outputs of the propagation time counter.
interface propagation_time_counter_if
  import propagation_time_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             i_Start;
  logic             i_Echo;
  logic             o_Ready;
  logic             o_Valid;
  logic [CNT_W-1:0] o_Time;
  logic             o_Timeout;
  logic             o_Missed;

  modport master (
    output i_Start, i_Echo,
    input  o_Ready, o_Valid, o_Time, o_Timeout, o_Missed
  );

  modport slave (
    input  i_Start, i_Echo,
    output o_Ready, o_Valid, o_Time, o_Timeout, o_Missed
  );
endinterface

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a registered single-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Rise
);
  logic s1_q, s2_q, hist_q, rise_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= i_Async;
      s2_q   <= s1_q;
      hist_q <= s2_q;
      rise_q <= s2_q & ~hist_q;
    end
  end

  assign o_Rise = rise_q;
endmodule

// File: rtl/propagation_time_counter.sv
// Measures clock cycles from a start rising edge to the next echo rising edge, with timeout.
module propagation_time_counter
  import propagation_time_counter_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  propagation_time_counter_if.slave   bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       arm_q, arm_d;
  logic [CNT_W-1:0] time_q, time_d;
  logic             tmo_q, tmo_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             missed_q, missed_d;
  logic             start_prev_q;
  logic             start_edge, echo_rise, armed, timeout_hit;

  sync_rise_detect u_echo_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (bus.i_Echo),
    .o_Rise  (echo_rise)
  );

  assign start_edge = bus.i_Start & ~start_prev_q;
  // cnt_q holds N of the echo pulse currently visible once the blanking cycles have elapsed
  assign armed       = (arm_q == BLANK_CYCLES);
  assign timeout_hit = armed && (cnt_q == TIMEOUT_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    time_d   = time_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    ready_d  = ready_q;
    missed_d = missed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
          arm_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_COUNT: begin
        if (start_edge) missed_d = 1'b1;
        if (armed && echo_rise) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          time_d  = cnt_q;
          tmo_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          time_d  = TIMEOUT_C;
          tmo_d   = 1'b1;
        end else if (!armed) begin
          arm_d = arm_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (start_edge) missed_d = 1'b1;
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      arm_q        <= '0;
      time_q       <= '0;
      tmo_q        <= 1'b0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b1;
      missed_q     <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arm_q        <= arm_d;
      time_q       <= time_d;
      tmo_q        <= tmo_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      missed_q     <= missed_d;
      start_prev_q <= bus.i_Start;
    end
  end

  assign bus.o_Ready   = ready_q;
  assign bus.o_Valid   = valid_q;
  assign bus.o_Time    = time_q;
  assign bus.o_Timeout = tmo_q;
  assign bus.o_Missed  = missed_q;
endmodule

// File: tb/tb_propagation_time_counter.sv
// Scoreboard bench for propagation_time_counter with TIMEOUT=100, CNT_W=16, 20 ns clock.
module tb_propagation_time_counter;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 16;

  typedef struct {
    int t;
    int tmo;
    int vedge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  propagation_time_counter_if #(.CNT_W(CNT_W)) bus ();

  propagation_time_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (bus.o_Ready !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    if (bus.o_Ready !== 1'b1) chk("ready_wait", int'(bus.o_Ready), 1);
  endtask

  // Results are compared at the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_Valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", int'(bus.o_Valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("time", int'(bus.o_Time), e.t);
        chk("timeout", int'(bus.o_Timeout), e.tmo);
        chk("valid_cycle", cyc, e.vedge);
        chk("ready_low_at_valid", int'(bus.o_Ready), 0);
      end
    end
  end

  task automatic drain(input int s, input int echo_n, input bit do_echo);
    int g = 0;
    while (sb.size() != 0 && g < TIMEOUT + 40) begin
      tick();
      g++;
      if (cyc == s) begin
        chk("ready_low", int'(bus.o_Ready), 0);
        bus.i_Start = 1'b0;
      end
      if (do_echo && echo_n > 0 && cyc == s + echo_n - 1) bus.i_Echo = 1'b1;
    end
    if (sb.size() != 0) begin
      chk("sb_drain", sb.size(), 0);
      sb.delete();
    end else begin
      tick();
      chk("ready_back", int'(bus.o_Ready), 1);
    end
  endtask

  // echo_n is the edge offset from S at which i_Echo is first sampled high
  task automatic run_meas(input int echo_n, input bit do_echo, input int et, input int etmo);
    int s;
    int lat;
    wait_ready();
    if (do_echo && echo_n < 0) begin
      bus.i_Echo = 1'b1;
      tick();
    end
    bus.i_Start = 1'b1;
    s = cyc + 1;
    if (do_echo && echo_n == 0) bus.i_Echo = 1'b1;
    lat = (etmo != 0) ? TIMEOUT : et;
    sb.push_back('{t: et, tmo: etmo, vedge: s + lat + 3});
    drain(s, echo_n, do_echo);
    bus.i_Start = 1'b0;
    bus.i_Echo  = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(bus.o_Ready), 1);
    chk({tag, "_valid"}, int'(bus.o_Valid), 0);
    chk({tag, "_time"}, int'(bus.o_Time), 0);
    chk({tag, "_timeout"}, int'(bus.o_Timeout), 0);
    chk({tag, "_missed"}, int'(bus.o_Missed), 0);
  endtask

  initial begin
    int s;
    int g;
    rst_n       = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_Echo  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.i_Start = ~bus.i_Start;
      bus.i_Echo  = bus.i_Start;
      tick();
    end
    @(negedge clk);
    check_reset_outputs("rst");
    bus.i_Start = 1'b0;
    bus.i_Echo  = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("idle_ready", int'(bus.o_Ready), 1);

    run_meas(37, 1'b1, 37, 0);
    run_meas(0, 1'b0, TIMEOUT, 1);
    run_meas(5, 1'b1, 5, 0);
    run_meas(0, 1'b1, 0, 0);
    run_meas(99, 1'b1, 99, 0);
    run_meas(-1, 1'b1, TIMEOUT, 1);
    chk("missed_clear", int'(bus.o_Missed), 0);

    // Echo already high at start plus a second start edge at S+10
    wait_ready();
    bus.i_Echo = 1'b1;
    tick();
    tick();
    bus.i_Start = 1'b1;
    s = cyc + 1;
    sb.push_back('{t: 30, tmo: 0, vedge: s + 33});
    g = 0;
    while (sb.size() != 0 && g < TIMEOUT + 40) begin
      tick();
      g++;
      if (cyc == s) bus.i_Start = 1'b0;
      if (cyc == s + 9) bus.i_Start = 1'b1;
      if (cyc == s + 10) begin
        chk("missed_set", int'(bus.o_Missed), 1);
        bus.i_Start = 1'b0;
      end
      if (cyc == s + 19) bus.i_Echo = 1'b0;
      if (cyc == s + 29) bus.i_Echo = 1'b1;
    end
    if (sb.size() != 0) begin
      chk("sb_drain_overrun", sb.size(), 0);
      sb.delete();
    end
    bus.i_Echo = 1'b0;
    tick();
    chk("missed_hold", int'(bus.o_Missed), 1);
    run_meas(8, 1'b1, 8, 0);
    chk("missed_sticky", int'(bus.o_Missed), 1);

    // Reset in the middle of a measurement
    wait_ready();
    bus.i_Start = 1'b1;
    s = cyc + 1;
    g = 0;
    while (cyc < s + 19 && g < 100) begin
      tick();
      g++;
      if (cyc == s) bus.i_Start = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (TIMEOUT + 10) tick();
    chk("midrst_idle_ready", int'(bus.o_Ready), 1);
    chk("midrst_idle_missed", int'(bus.o_Missed), 0);
    run_meas(12, 1'b1, 12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
